// File: rtl/router_pkg.sv
// Shared types and constants for the router control path.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  localparam logic [1:0] ADDR_0       = 2'b00;
  localparam logic [1:0] ADDR_1       = 2'b01;
  localparam logic [1:0] ADDR_2       = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int unsigned SR_TIMEOUT_DEF = 30;

  // Invalid address maps to no output at all.
  function automatic logic [2:0] addr_onehot(input logic [1:0] addr);
    logic [2:0] oh;
    oh = 3'b000;
    case (addr)
      ADDR_0:  oh = 3'b001;
      ADDR_1:  oh = 3'b010;
      ADDR_2:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_sr_timer.sv
// Per-output idle timer: pulses soft_reset when a FIFO holds data unread for SR_TIMEOUT cycles.
module router_sr_timer
  import router_pkg::*;
#(
  parameter int unsigned SR_TIMEOUT = SR_TIMEOUT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic fifo_empty,
  input  logic read_enb,
  output logic soft_reset
);

  localparam int unsigned CntW = $clog2(SR_TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SR_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = 1'b0;
    if (fifo_empty || read_enb) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
      sr_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
      sr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign soft_reset = sr_q;

endmodule

// File: rtl/router_ctrl_fsm.sv
// Router control FSM: sequences header/payload/parity writes into the three output FIFOs.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int unsigned SR_TIMEOUT = SR_TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic [2:0] soft_reset
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [2:0] addr_oh;
  logic       tgt_full;

  for (genvar i = 0; i < 3; i++) begin : gen_sr_timer
    router_sr_timer #(
      .SR_TIMEOUT(SR_TIMEOUT)
    ) u_sr_timer (
      .clock     (clock),
      .resetn    (resetn),
      .fifo_empty(fifo_empty[i]),
      .read_enb  (read_enb[i]),
      .soft_reset(soft_reset[i])
    );
  end

  assign addr_oh  = addr_onehot(addr_q);
  assign tgt_full = |(fifo_full & addr_oh);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && (data_in != ADDR_INVALID)) begin
          addr_d  = data_in;
          state_d = |(fifo_empty & addr_onehot(data_in)) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (tgt_full)        state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!tgt_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = tgt_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (|(fifo_empty & addr_oh)) state_d = LOAD_FIRST_DATA;
      end
    endcase
    // A timed-out target FIFO aborts the packet in flight; other outputs are ignored.
    if ((state_q != DECODE_ADDRESS) && |(soft_reset & addr_oh)) begin
      state_d = DECODE_ADDRESS;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= ADDR_0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      DECODE_ADDRESS:  detect_add = 1'b1;
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      WAIT_TILL_EMPTY: busy = 1'b1;
    endcase
  end

  assign write_enb = write_enb_reg ? addr_oh : 3'b000;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed self-checking bench for router_ctrl_fsm.
module tb_router_ctrl_fsm;

  // Decoded outputs: {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
  localparam logic [7:0] D_DA   = 8'b1000_0000;
  localparam logic [7:0] D_LFD  = 8'b0100_0001;
  localparam logic [7:0] D_LD   = 8'b0010_0010;
  localparam logic [7:0] D_LAF  = 8'b0001_0011;
  localparam logic [7:0] D_FULL = 8'b0000_1001;
  localparam logic [7:0] D_LP   = 8'b0000_0011;
  localparam logic [7:0] D_CPE  = 8'b0000_0101;
  localparam logic [7:0] D_WTE  = 8'b0000_0001;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;
  logic [2:0] write_enb;
  logic [2:0] soft_reset;
  logic [7:0] dec;

  int n_tests = 0;
  int n_fail  = 0;

  router_ctrl_fsm #(
    .SR_TIMEOUT(30)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .read_enb     (read_enb),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .write_enb_reg(write_enb_reg),
    .busy         (busy),
    .write_enb    (write_enb),
    .soft_reset   (soft_reset)
  );

  assign dec = {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_st(input string tag, input logic [7:0] exp_dec, input logic [2:0] exp_we);
    check(tag, 32'({dec, write_enb}), 32'({exp_dec, exp_we}));
  endtask

  task automatic chk_sr(input string tag, input logic [2:0] exp_sr);
    check(tag, 32'(soft_reset), 32'(exp_sr));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn        = 1'b0;
    pkt_valid     = 1'b0;
    data_in       = 2'b00;
    fifo_full     = 3'b000;
    fifo_empty    = 3'b111;
    read_enb      = 3'b000;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
    step();
    step();
    chk_st("reset_state", D_DA, 3'b000);
    chk_sr("reset_sr", 3'b000);
    resetn = 1'b1;

    // Addr 01, 4-byte payload then parity
    pkt_valid = 1'b1;
    data_in   = 2'b01;
    step(); chk_st("p1_lfd", D_LFD, 3'b000);
    step(); chk_st("p1_ld1", D_LD, 3'b010);
    step(); chk_st("p1_ld2", D_LD, 3'b010);
    step(); chk_st("p1_ld3", D_LD, 3'b010);
    step(); chk_st("p1_ld4", D_LD, 3'b010);
    pkt_valid = 1'b0;
    step(); chk_st("p1_lp", D_LP, 3'b010);
    step(); chk_st("p1_cpe", D_CPE, 3'b000);
    step(); chk_st("p1_da", D_DA, 3'b000);

    // Addr 00 with full stalls
    pkt_valid = 1'b1;
    data_in   = 2'b00;
    step(); chk_st("p2_lfd", D_LFD, 3'b000);
    step(); chk_st("p2_ld", D_LD, 3'b001);
    fifo_full = 3'b001;
    step(); chk_st("p2_full1", D_FULL, 3'b000);
    step(); chk_st("p2_full2", D_FULL, 3'b000);
    step(); chk_st("p2_full3", D_FULL, 3'b000);
    fifo_full = 3'b000;
    step(); chk_st("p2_laf", D_LAF, 3'b001);
    step(); chk_st("p2_laf_ld", D_LD, 3'b001);
    fifo_full = 3'b001;
    step(); chk_st("p2_full_b", D_FULL, 3'b000);
    fifo_full     = 3'b000;
    low_pkt_valid = 1'b1;
    step(); chk_st("p2_laf_b", D_LAF, 3'b001);
    step(); chk_st("p2_lp", D_LP, 3'b001);
    low_pkt_valid = 1'b0;
    fifo_full     = 3'b001;
    step(); chk_st("p2_cpe", D_CPE, 3'b000);
    step(); chk_st("p2_cpe_full", D_FULL, 3'b000);
    fifo_full   = 3'b000;
    parity_done = 1'b1;
    step(); chk_st("p2_laf_c", D_LAF, 3'b001);
    pkt_valid = 1'b0;
    step(); chk_st("p2_pd_da", D_DA, 3'b000);
    parity_done = 1'b0;

    // Invalid header dropped
    pkt_valid = 1'b1;
    data_in   = 2'b11;
    step(); chk_st("inv_1", D_DA, 3'b000);
    step(); chk_st("inv_2", D_DA, 3'b000);
    pkt_valid = 1'b0;

    // Addr 10 waits for FIFO2 to drain; latched addr must hold
    pkt_valid  = 1'b1;
    data_in    = 2'b10;
    fifo_empty = 3'b011;
    step(); chk_st("w_1", D_WTE, 3'b000);
    pkt_valid = 1'b0;
    data_in   = 2'b00;
    for (int i = 2; i <= 5; i++) begin
      step(); chk_st($sformatf("w_%0d", i), D_WTE, 3'b000);
    end
    fifo_empty = 3'b111;
    step(); chk_st("w_lfd", D_LFD, 3'b000);
    step(); chk_st("w_ld", D_LD, 3'b100);
    step(); chk_st("w_lp", D_LP, 3'b100);
    step(); chk_st("w_cpe", D_CPE, 3'b000);
    step(); chk_st("w_da", D_DA, 3'b000);

    // Timeout on output 1: pulse on 30th idle cycle, single cycle
    fifo_empty = 3'b101;
    for (int i = 1; i <= 29; i++) begin
      step(); chk_sr($sformatf("to_idle_%0d", i), 3'b000);
    end
    step(); chk_sr("to_pulse", 3'b010);
    step(); chk_sr("to_single", 3'b000);
    fifo_empty = 3'b111;
    step();

    // Read strobe on cycle 20 restarts the count
    fifo_empty = 3'b101;
    for (int i = 1; i <= 49; i++) begin
      read_enb = (i == 20) ? 3'b010 : 3'b000;
      step(); chk_sr($sformatf("rd_idle_%0d", i), 3'b000);
    end
    read_enb = 3'b000;
    step(); chk_sr("rd_pulse", 3'b010);
    fifo_empty = 3'b111;
    step();

    // Non-target timeout ignored, target timeout aborts
    fifo_empty = 3'b110;
    step();
    pkt_valid = 1'b1;
    data_in   = 2'b01;
    step(); chk_st("ab_lfd", D_LFD, 3'b000);
    fifo_empty = 3'b100;
    step(); chk_st("ab_ld", D_LD, 3'b010);
    for (int k = 1; k <= 26; k++) begin
      step(); chk_sr($sformatf("ab_idle_%0d", k), 3'b000);
    end
    step(); chk_sr("ab_sr0", 3'b001); chk_st("ab_ld_sr0", D_LD, 3'b010);
    step(); chk_sr("ab_sr0_end", 3'b000); chk_st("ab_ignore", D_LD, 3'b010);
    step(); chk_sr("ab_sr1", 3'b010); chk_st("ab_ld_sr1", D_LD, 3'b010);
    pkt_valid = 1'b0;
    step(); chk_st("ab_abort", D_DA, 3'b000);
    fifo_empty = 3'b111;
    step();

    // Reset during LOAD_DATA clears state and counters
    fifo_empty = 3'b011;
    pkt_valid  = 1'b1;
    data_in    = 2'b00;
    step(); chk_st("rs_lfd", D_LFD, 3'b000);
    step(); chk_st("rs_ld", D_LD, 3'b001);
    step();
    resetn = 1'b0;
    step(); chk_st("rs_da", D_DA, 3'b000); chk_sr("rs_sr", 3'b000);
    resetn    = 1'b1;
    pkt_valid = 1'b0;
    for (int i = 1; i <= 29; i++) begin
      step(); chk_sr($sformatf("rs_idle_%0d", i), 3'b000);
    end
    step(); chk_sr("rs_pulse", 3'b100); chk_st("rs_da_hold", D_DA, 3'b000);
    step(); chk_sr("rs_single", 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
